vga_write_arbiter: RTL and testbench

- Shares the single BitmapToVga write port (x, y, color, wr_en) between two pixel requesters, for example the Pong game engine and a score/overlay drawer.
- Contains a built-in screen-clear sequencer that sweeps the whole bitmap with a fixed colour.
- Sits between the game logic and the bitmap/VGA block in the 100 MHz domain.
- Grants at most one write per cycle; all bitmap-side outputs are registered.

---
 rtl/vga_write_arbiter.sv | 165 ++++++++++++++++
 tb/tb_vga_write_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vga_write_arbiter.sv
// vga_write_arbiter: shares the single bitmap write port between two pixel
// requesters and a built-in screen-clear sequencer. One write per cycle at
// most. Every bitmap-side output comes from a flop, so a pixel granted in
// cycle k is written in cycle k+1.
module vga_write_arbiter #(
  parameter int         WIDTH       = 320,
  parameter int         HEIGHT      = 240,
  parameter logic [2:0] CLEAR_COLOR = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear_start,
  output logic       busy,
  output logic       clear_done,
  input  logic       r0_valid,
  output logic       r0_ready,
  input  logic [8:0] r0_x,
  input  logic [7:0] r0_y,
  input  logic [2:0] r0_color,
  input  logic       r1_valid,
  output logic       r1_ready,
  input  logic [8:0] r1_x,
  input  logic [7:0] r1_y,
  input  logic [2:0] r1_color,
  output logic [8:0] vga_x,
  output logic [7:0] vga_y,
  output logic [2:0] vga_color,
  output logic       vga_wr_en,
  output logic       oob_drop
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  localparam logic [8:0] X_LAST = 9'(WIDTH - 1);
  localparam logic [7:0] Y_LAST = 8'(HEIGHT - 1);

  logic [0:0] state_q, state_d;
  logic [8:0] cx_q, cx_d;
  logic [7:0] cy_q, cy_d;
  // Requester that won the most recent grant; the other one wins a tie.
  logic       last_grant_q, last_grant_d;

  logic [8:0] vga_x_q, vga_x_d;
  logic [7:0] vga_y_q, vga_y_d;
  logic [2:0] vga_color_q, vga_color_d;
  logic       vga_wr_en_q, vga_wr_en_d;
  logic       oob_drop_q, oob_drop_d;
  logic       clear_done_q, clear_done_d;

  logic       grant_ok;
  logic       gnt0, gnt1;
  logic [8:0] sel_x;
  logic [7:0] sel_y;
  logic [2:0] sel_color;
  logic       sel_oob;

  // Round-robin arbitration between the requesters; clear_start pre-empts both.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    grant_ok  = !reset && (state_q == IDLE) && !clear_start;
    gnt0      = grant_ok && r0_valid && (!r1_valid || last_grant_q);
    gnt1      = grant_ok && r1_valid && (!r0_valid || !last_grant_q);
    sel_x     = gnt1 ? r1_x     : r0_x;
    sel_y     = gnt1 ? r1_y     : r0_y;
    sel_color = gnt1 ? r1_color : r0_color;
    sel_oob   = (int'(sel_x) >= WIDTH) || (int'(sel_y) >= HEIGHT);
  end

  assign r0_ready = gnt0;
  assign r1_ready = gnt1;

  // Next-state logic: IDLE serves requesters, CLEAR sweeps the bitmap row-major.
  always_comb begin
    state_d      = state_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    last_grant_d = last_grant_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_color_d  = vga_color_q;
    vga_wr_en_d  = 1'b0;
    oob_drop_d   = 1'b0;
    clear_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d = CLEAR;
          cx_d    = '0;
          cy_d    = '0;
        end else if (gnt0 || gnt1) begin
          last_grant_d = gnt1;
          if (sel_oob) begin
            // Out-of-range pixels are consumed but never reach the bitmap.
            oob_drop_d = 1'b1;
          end else begin
            vga_wr_en_d = 1'b1;
            vga_x_d     = sel_x;
            vga_y_d     = sel_y;
            vga_color_d = sel_color;
          end
        end
      end
      CLEAR: begin
        vga_wr_en_d = 1'b1;
        vga_x_d     = cx_q;
        vga_y_d     = cy_q;
        vga_color_d = CLEAR_COLOR;
        if (cx_q == X_LAST) begin
          cx_d = '0;
          if (cy_q == Y_LAST) begin
            cy_d         = '0;
            state_d      = IDLE;
            clear_done_d = 1'b1;
          end else begin
            cy_d = cy_q + 8'd1;
          end
        end else begin
          cx_d = cx_q + 9'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q      <= IDLE;
      cx_q         <= '0;
      cy_q         <= '0;
      last_grant_q <= 1'b1;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_color_q  <= '0;
      vga_wr_en_q  <= 1'b0;
      oob_drop_q   <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      last_grant_q <= last_grant_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_color_q  <= vga_color_d;
      vga_wr_en_q  <= vga_wr_en_d;
      oob_drop_q   <= oob_drop_d;
      clear_done_q <= clear_done_d;
    end
  end

  assign busy       = (state_q == CLEAR);
  assign clear_done = clear_done_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_color  = vga_color_q;
  assign vga_wr_en  = vga_wr_en_q;
  assign oob_drop   = oob_drop_q;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Scoreboard bench for vga_write_arbiter: stimulus pushes the expected bitmap
// write for every grant or clear pixel; a monitor pops and compares whenever
// the DUT shows wr_en, oob_drop or clear_done.
`timescale 1ns/1ps
module tb_vga_write_arbiter;

  localparam int W = 320;
  localparam int H = 240;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear_start;
  logic       busy, clear_done;
  logic       r0_valid, r0_ready;
  logic [8:0] r0_x;
  logic [7:0] r0_y;
  logic [2:0] r0_color;
  logic       r1_valid, r1_ready;
  logic [8:0] r1_x;
  logic [7:0] r1_y;
  logic [2:0] r1_color;
  logic [8:0] vga_x;
  logic [7:0] vga_y;
  logic [2:0] vga_color;
  logic       vga_wr_en, oob_drop;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
    logic       wr;
    logic       oob;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   vectors    = 0;
  int   miscompares = 0;

  vga_write_arbiter #(.WIDTH(W), .HEIGHT(H), .CLEAR_COLOR(3'b000)) dut (
    .clk(clk), .reset(reset), .clear_start(clear_start),
    .busy(busy), .clear_done(clear_done),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_x(r0_x), .r0_y(r0_y), .r0_color(r0_color),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_x(r1_x), .r1_y(r1_y), .r1_color(r1_color),
    .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color),
    .vga_wr_en(vga_wr_en), .oob_drop(oob_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int x, input int y, input int c,
                              input bit wr, input bit oob, input bit done);
    exp_t e;
    e.x = 9'(x); e.y = 8'(y); e.c = 3'(c);
    e.wr = wr; e.oob = oob; e.done = done;
    return e;
  endfunction

  // Expected clear pixel number idx in row-major order.
  function automatic exp_t clr(input int idx, input bit done);
    return mk(idx % W, idx / W, 0, 1'b1, 1'b0, done);
  endfunction

  task automatic next_cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare every visible output event against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (vga_wr_en === 1'b1 || oob_drop === 1'b1 || clear_done === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_output", {29'd0, vga_wr_en, oob_drop, clear_done}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("out_flags", {29'd0, vga_wr_en, oob_drop, clear_done},
                {29'd0, e.wr, e.oob, e.done});
          if (e.wr)
            check("out_pixel", {12'd0, vga_x, vga_y, vga_color}, {12'd0, e.x, e.y, e.c});
        end
      end
    end
  end

  // Watchdog: the whole run is about 78k cycles.
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; clear_start = 1'b0;
    r0_valid = 1'b0; r0_x = '0; r0_y = '0; r0_color = '0;
    r1_valid = 1'b0; r1_x = '0; r1_y = '0; r1_color = '0;
    next_cycle(3);
    reset = 1'b0;

    // Reset state held for 10 idle cycles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("reset_idle", {8'd0, vga_x, vga_y, vga_color, vga_wr_en, busy, clear_done,
                           oob_drop, r0_ready, r1_ready}, 32'd0);
      next_cycle(1);
    end

    // Both requesters valid: first tie goes to r0, then strict alternation.
    r0_valid = 1'b1; r0_x = 9'd1; r0_y = 8'd2; r0_color = 3'd3;
    r1_valid = 1'b1; r1_x = 9'd4; r1_y = 8'd5; r1_color = 3'd6;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("alt_r0_ready", {31'd0, r0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("alt_r1_ready", {31'd0, r1_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      if (i % 2 == 0) sb.push_back(mk(1, 2, 3, 1'b1, 1'b0, 1'b0));
      else            sb.push_back(mk(4, 5, 6, 1'b1, 1'b0, 1'b0));
      next_cycle(1);
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    next_cycle(3);

    // r0 alone: (10,20,5).
    r0_valid = 1'b1; r0_x = 9'd10; r0_y = 8'd20; r0_color = 3'b101;
    @(negedge clk);
    check("r0_only_ready", {30'd0, r0_ready, r1_ready}, 32'b10);
    sb.push_back(mk(10, 20, 5, 1'b1, 1'b0, 1'b0));
    next_cycle(1);
    r0_valid = 1'b0;
    next_cycle(3);

    // r1 with x out of range, then y out of range: accepted but dropped.
    r1_valid = 1'b1; r1_x = 9'd320; r1_y = 8'd5; r1_color = 3'd1;
    @(negedge clk);
    check("oob_x_ready", {30'd0, r0_ready, r1_ready}, 32'b01);
    sb.push_back(mk(0, 0, 0, 1'b0, 1'b1, 1'b0));
    next_cycle(1);
    r1_valid = 1'b0;
    next_cycle(3);
    r1_valid = 1'b1; r1_x = 9'd5; r1_y = 8'd240; r1_color = 3'd1;
    @(negedge clk);
    check("oob_y_ready", {30'd0, r0_ready, r1_ready}, 32'b01);
    sb.push_back(mk(0, 0, 0, 1'b0, 1'b1, 1'b0));
    next_cycle(1);
    r1_valid = 1'b0;
    next_cycle(3);

    // Clear aborted by reset during cycle C+1000: pixels 0..998 reach the output.
    clear_start = 1'b1;
    for (int k = 0; k < 999; k++) sb.push_back(clr(k, 1'b0));
    next_cycle(1);
    clear_start = 1'b0;
    @(negedge clk);
    check("abort_busy_c1", {31'd0, busy}, 32'd1);
    next_cycle(999);
    reset = 1'b1;
    next_cycle(1);
    reset = 1'b0;
    @(negedge clk);
    check("abort_outputs", {29'd0, vga_wr_en, busy, clear_done}, 32'd0);
    check("abort_sb_empty", 32'(sb.size()), 32'd0);
    next_cycle(5);

    // Full clear with r0 waiting; a second clear_start mid-sweep is ignored.
    r0_valid = 1'b1; r0_x = 9'd7; r0_y = 8'd7; r0_color = 3'd2;
    clear_start = 1'b1;
    @(negedge clk);
    check("clear_start_ready", {30'd0, r0_ready, r1_ready}, 32'd0);
    for (int k = 0; k < W * H; k++) sb.push_back(clr(k, k == W * H - 1));
    next_cycle(1);
    for (int i = 1; i <= W * H; i++) begin
      clear_start = (i == 100);
      @(negedge clk);
      check("clear_busy_ready", {30'd0, busy, r0_ready}, 32'b10);
      next_cycle(1);
    end
    clear_start = 1'b0;
    @(negedge clk);
    check("post_clear_grant", {30'd0, busy, r0_ready}, 32'b01);
    sb.push_back(mk(7, 7, 2, 1'b1, 1'b0, 1'b0));
    next_cycle(1);
    r0_valid = 1'b0;
    next_cycle(5);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
